gate_tt_sequencer: RTL and testbench

Truth-table sequencer and checker for a two-input gate under test, such as the NAND-built OR. On `start` it drives the four input vectors in order and waits a programmable settle time on each. It samples the gate output, assembles the 4-bit truth table and compares it against an expected table. It sits between a test/control host and a combinational gate instance, replacing hand-written stimulus sequences with a single handshake.

---
 rtl/gate_tt_sequencer_if.sv | 42 ++++
 rtl/gate_tt_sequencer.sv | 161 ++++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_sequencer_if.sv
// ----------------------------------------------------------------------------
// gate_tt_sequencer_if
//   Control-side bundle between a test/control host and gate_tt_sequencer.
//
//   Handshake: the host raises `start` as a run request. The sequencer accepts
//   it only on an edge where it is idle; a request seen while `busy` is high,
//   or in the `done` cycle, is dropped, and it is not remembered. `busy` is
//   high while vectors are being driven. `done` pulses for one cycle when a
//   run completes. `truth_table`, `mismatch` and `pass` are valid from that
//   cycle and are held until the next accepted start. `abort` ends a running
//   sequence on the next edge and produces no `done` pulse.
//
//   Signals (directions as seen by the sequencer, modport slave):
//     start        in   run request
//     abort        in   synchronous abort of a running sequence
//     busy         out  sequence running
//     done         out  one-cycle completion pulse
//     truth_table  out  captured table, bit i = sample for vector i
//     mismatch     out  truth_table ^ expected table
//     pass         out  mismatch == 0
//     dbg_state    out  raw FSM state (0 idle, 1 drive, 2 done)
// ----------------------------------------------------------------------------
interface gate_tt_sequencer_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [3:0] mismatch;
    logic       pass;
    logic [1:0] dbg_state;

    modport master (
        output start, abort,
        input  busy, done, truth_table, mismatch, pass, dbg_state
    );

    modport slave (
        input  start, abort,
        output busy, done, truth_table, mismatch, pass, dbg_state
    );
endinterface

// File: rtl/gate_tt_sequencer.sv
// ----------------------------------------------------------------------------
// gate_tt_sequencer
//   Drives the four input vectors {a,b} = 00, 01, 10, 11 into a two-input
//   combinational gate. Each vector is held for SETTLE_CYCLES cycles, then the
//   gate output is sampled. The 4-bit truth table is assembled and compared
//   with EXPECT.
//
//   Parameters:
//     SETTLE_CYCLES  cycles between driving a vector and sampling (0..255)
//     EXPECT         expected table, bit i = output for {a,b} = i
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     ctl        slave side of gate_tt_sequencer_if (start/abort/status)
//     a, b       out  registered gate inputs
//     dut_out    in   gate output
//     err_count  out  (only with GATE_TT_ERRCNT_EN) saturating count of
//                     completed runs that failed
//
//   Build option: define GATE_TT_ERRCNT_EN to add the err_count output.
// ----------------------------------------------------------------------------
module gate_tt_sequencer #(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [3:0] EXPECT        = 4'b1110
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_tt_sequencer_if.slave   ctl,
    output logic                 a,
    output logic                 b,
    input  logic                 dut_out
`ifdef GATE_TT_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] ab_q,    ab_d;      // {a,b}
    logic [3:0] tt_q,    tt_d;
    logic [3:0] mm_q,    mm_d;
    logic       pass_q,  pass_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            ab_q    <= 2'b00;
            tt_q    <= 4'd0;
            mm_q    <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                // abort is meaningless here, so a coincident start still wins.
                if (ctl.start) begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = SETTLE_LD;
                    ab_d    = 2'b00;
                    tt_d    = 4'd0;
                    mm_d    = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (ctl.abort) begin
                    // Partial table is kept for inspection; no result is reported.
                    state_d = ST_IDLE;
                    ab_d    = 2'b00;
                    pass_d  = 1'b0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    tt_d[idx_q] = dut_out;
                    if (idx_q == 2'd3) begin
                        // Result is registered on entry to DONE so that it is
                        // already valid while done is high.
                        state_d = ST_DONE;
                        ab_d    = 2'b00;
                        mm_d    = tt_d ^ EXPECT;
                        pass_d  = (tt_d == EXPECT);
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = SETTLE_LD;
                        ab_d  = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ab_d    = 2'b00;
            end
        endcase
    end

    assign a               = ab_q[1];
    assign b               = ab_q[0];
    assign ctl.busy        = (state_q == ST_DRIVE);
    assign ctl.done        = (state_q == ST_DONE);
    assign ctl.truth_table = tt_q;
    assign ctl.mismatch    = mm_q;
    assign ctl.pass        = pass_q;
    assign ctl.dbg_state   = state_q;

`ifdef GATE_TT_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // Counted as the DONE cycle retires; pass_q already holds this run's result.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_DONE && !pass_q && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gate_tt_sequencer
//   Two sequencers share clock and reset:
//     u_dut1  SETTLE_CYCLES=1, drives a NAND-built OR gate model
//     u_dut0  SETTLE_CYCLES=0, drives a stuck-at-0 gate model
//   Directed scenarios with hand-computed expectations; the per-cycle {a,b}
//   sequence comes from an expected queue filled by a small vector model.
// ----------------------------------------------------------------------------
module tb_gate_tt_sequencer;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs and gate models ----------------
    gate_tt_sequencer_if if1 ();
    gate_tt_sequencer_if if0 ();

    logic a1, b1, out1;
    logic a0, b0, out0;

    // OR built from NANDs: nand(nand(a,a), nand(b,b))
    assign out1 = ~((~(a1 & a1)) & (~(b1 & b1)));
    assign out0 = 1'b0;

`ifdef GATE_TT_ERRCNT_EN
    logic [7:0] err1, err0;
`endif

    gate_tt_sequencer #(.SETTLE_CYCLES(1), .EXPECT(4'b1110)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl       (if1.slave),
        .a         (a1),
        .b         (b1),
        .dut_out   (out1)
`ifdef GATE_TT_ERRCNT_EN
        ,
        .err_count (err1)
`endif
    );

    gate_tt_sequencer #(.SETTLE_CYCLES(0), .EXPECT(4'b1110)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl       (if0.slave),
        .a         (a0),
        .b         (b0),
        .dut_out   (out0)
`ifdef GATE_TT_ERRCNT_EN
        ,
        .err_count (err0)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge: one cycle later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {a,b} per DRIVE cycle: each vector held S+1 cycles.
    task automatic load_vectors(input int s);
        exp_q.delete();
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k <= s; k++) begin
                exp_q.push_back(2'(v));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Full OR run on u_dut1 with start in cycle 0. A start held in the done
    // cycle must be ignored.
    task automatic run_or_full(input string tag);
        logic [1:0] e;
        load_vectors(1);
        if1.start = 1'b1;
        tick();                               // cycle 1
        if1.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            e = exp_q.pop_front();
            check({tag, "_ab"},   {30'd0, a1, b1}, {30'd0, e});
            check({tag, "_busy"}, {31'd0, if1.busy}, 32'd1);
            check({tag, "_done"}, {31'd0, if1.done}, 32'd0);
            tick();
        end
        // cycle 9
        check({tag, "_done9"}, {31'd0, if1.done}, 32'd1);
        check({tag, "_busy9"}, {31'd0, if1.busy}, 32'd0);
        check({tag, "_ab9"},   {30'd0, a1, b1}, 32'd0);
        check({tag, "_tt"},    {28'd0, if1.truth_table}, 32'b1110);
        check({tag, "_mm"},    {28'd0, if1.mismatch}, 32'd0);
        check({tag, "_pass"},  {31'd0, if1.pass}, 32'd1);
        if1.start = 1'b1;                     // coincident with done
        tick();                               // cycle 10
        if1.start = 1'b0;
        check({tag, "_busy10"}, {31'd0, if1.busy}, 32'd0);
        check({tag, "_done10"}, {31'd0, if1.done}, 32'd0);
        check({tag, "_pass10"}, {31'd0, if1.pass}, 32'd1);
        tick();
    endtask

    // Stuck-at-0 run on u_dut0 (S=0), start in cycle 0.
    task automatic run_stuck_full(input string tag, input logic with_abort);
        logic [1:0] e;
        load_vectors(0);
        if0.start = 1'b1;
        if0.abort = with_abort;
        tick();                               // cycle 1
        if0.start = 1'b0;
        if0.abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            e = exp_q.pop_front();
            check({tag, "_ab"},   {30'd0, a0, b0}, {30'd0, e});
            check({tag, "_busy"}, {31'd0, if0.busy}, 32'd1);
            tick();
        end
        // cycle 5
        check({tag, "_done5"}, {31'd0, if0.done}, 32'd1);
        check({tag, "_tt"},    {28'd0, if0.truth_table}, 32'd0);
        check({tag, "_mm"},    {28'd0, if0.mismatch}, 32'b1110);
        check({tag, "_pass"},  {31'd0, if0.pass}, 32'd0);
        tick();                               // cycle 6
        check({tag, "_done6"}, {31'd0, if0.done}, 32'd0);
    endtask

    task automatic quick_run0();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        repeat (5) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        if1.start = 1'b1;
        if1.abort = 1'b0;
        if0.start = 1'b1;
        if0.abort = 1'b0;

        // Reset held with start asserted
        repeat (3) tick();
        check("rst_ab",    {30'd0, a1, b1}, 32'd0);
        check("rst_busy",  {31'd0, if1.busy}, 32'd0);
        check("rst_done",  {31'd0, if1.done}, 32'd0);
        check("rst_tt",    {28'd0, if1.truth_table}, 32'd0);
        check("rst_mm",    {28'd0, if1.mismatch}, 32'd0);
        check("rst_pass",  {31'd0, if1.pass}, 32'd0);
        check("rst_state", {30'd0, if1.dbg_state}, 32'd0);
        check("rst_busy0", {31'd0, if0.busy}, 32'd0);
`ifdef GATE_TT_ERRCNT_EN
        check("rst_err0", {24'd0, err0}, 32'd0);
`endif
        if1.start = 1'b0;
        if0.start = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        // Nominal OR run, S=1
        run_or_full("or");

        // Stuck-at-0, S=0
        run_stuck_full("stuck", 1'b0);
`ifdef GATE_TT_ERRCNT_EN
        check("stuck_err", {24'd0, err0}, 32'd1);
`endif

        // start and abort together in IDLE: start is taken
        run_stuck_full("stab", 1'b1);
`ifdef GATE_TT_ERRCNT_EN
        check("stab_err", {24'd0, err0}, 32'd2);
`endif

        // Start while busy, then abort
        if1.start = 1'b1;
        tick();                               // cycle 1
        if1.start = 1'b0;
        tick();                               // cycle 2
        tick();                               // cycle 3
        if1.start = 1'b1;
        tick();                               // cycle 4
        if1.start = 1'b0;
        check("ab_restart_ab",   {30'd0, a1, b1}, 32'b01);
        check("ab_restart_busy", {31'd0, if1.busy}, 32'd1);
        tick();                               // cycle 5
        if1.abort = 1'b1;
        tick();                               // cycle 6
        if1.abort = 1'b0;
        check("abort_busy", {31'd0, if1.busy}, 32'd0);
        check("abort_ab",   {30'd0, a1, b1}, 32'd0);
        check("abort_done", {31'd0, if1.done}, 32'd0);
        check("abort_tt",   {28'd0, if1.truth_table}, 32'b0010);
        check("abort_pass", {31'd0, if1.pass}, 32'd0);
        for (int c = 7; c <= 14; c++) begin
            tick();
            check("abort_nodone", {31'd0, if1.done}, 32'd0);
        end

        // Reset pulsed mid-run at cycle 4
        if1.start = 1'b1;
        tick();                               // cycle 1
        if1.start = 1'b0;
        repeat (3) tick();                    // cycle 4
        check("mid_pre_busy", {31'd0, if1.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, if1.busy}, 32'd0);
        check("mid_ab",   {30'd0, a1, b1}, 32'd0);
        check("mid_done", {31'd0, if1.done}, 32'd0);
        check("mid_tt",   {28'd0, if1.truth_table}, 32'd0);
        check("mid_pass", {31'd0, if1.pass}, 32'd0);
        check("mid_mm0",  {28'd0, if0.mismatch}, 32'd0);
`ifdef GATE_TT_ERRCNT_EN
        check("mid_err0", {24'd0, err0}, 32'd0);
`endif
        tick();
        #2 rst_n = 1'b1;
        tick();
        run_or_full("post_rst");

`ifdef GATE_TT_ERRCNT_EN
        // Saturation of the failure counter
        repeat (254) quick_run0();
        check("sat_254", {24'd0, err0}, 32'd254);
        repeat (6) quick_run0();
        check("sat_255", {24'd0, err0}, 32'd255);
        quick_run0();
        check("sat_hold", {24'd0, err0}, 32'd255);
        check("sat_err1", {24'd0, err1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
